// File: rtl/run_ctrl_pkg.sv
// Shared types for the run controller: FSM state encoding and termination status codes.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RST  = 2'd1,
        S_RUN  = 2'd2,
        S_END  = 2'd3
    } state_t;

    localparam logic [1:0] STAT_NONE   = 2'b00;
    localparam logic [1:0] STAT_HALT   = 2'b01;
    localparam logic [1:0] STAT_BUDGET = 2'b10;
    localparam logic [1:0] STAT_WDOG   = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clear wins over inc.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/run_controller.sv
// Sequences a core through reset and a bounded run, reporting why the run ended.
//
// state | meaning
// IDLE  | waiting for start after reset release
// RST   | core held in reset for RST_CYCLES cycles
// RUN   | core running; counters advance, termination checked every cycle
// END   | run finished; counters and status frozen until the next start
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int RST_CYCLES  = 2,
    parameter int MAX_CYCLES  = 100,
    parameter int WDOG_CYCLES = 32,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt,
    input  logic             retire,
    output logic             core_rst_n,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RST_CYCLES - 1);

    state_t           state_q, state_d;
    logic [RST_W-1:0] rst_tmr_q, rst_tmr_d;
    logic [1:0]       status_d;
    logic             clear_cnt;
    logic             in_run;
    logic [CNT_W-1:0] wdog_cnt;
    logic [CNT_W:0]   cycle_nxt, wdog_nxt;
    logic             budget_hit, wdog_hit;

    assign in_run = (state_q == S_RUN);

    // Termination looks at the counter values this RUN cycle will produce.
    assign cycle_nxt  = {1'b0, cycle_cnt} + (CNT_W+1)'(1);
    assign wdog_nxt   = {1'b0, wdog_cnt} + (CNT_W+1)'(1);
    assign budget_hit = (cycle_nxt >= (CNT_W+1)'(MAX_CYCLES));
    assign wdog_hit   = !retire && (wdog_nxt >= (CNT_W+1)'(WDOG_CYCLES));

    always_comb begin
        state_d   = state_q;
        rst_tmr_d = rst_tmr_q;
        status_d  = status;
        clear_cnt = 1'b0;
        case (state_q)
            S_IDLE, S_END: begin
                if (start) begin
                    state_d   = S_RST;
                    rst_tmr_d = RST_LOAD;
                    status_d  = STAT_NONE;
                    clear_cnt = 1'b1;
                end
            end
            S_RST: begin
                if (rst_tmr_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    rst_tmr_d = rst_tmr_q - RST_W'(1);
                end
            end
            S_RUN: begin
                if (halt) begin
                    state_d  = S_END;
                    status_d = STAT_HALT;
                end else if (budget_hit) begin
                    state_d  = S_END;
                    status_d = STAT_BUDGET;
                end else if (wdog_hit) begin
                    state_d  = S_END;
                    status_d = STAT_WDOG;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            rst_tmr_q  <= '0;
            status     <= STAT_NONE;
            core_rst_n <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_tmr_q  <= rst_tmr_d;
            status     <= status_d;
            core_rst_n <= (state_d == S_RUN);
            busy       <= (state_d == S_RST) || (state_d == S_RUN);
            done       <= (state_d == S_END);
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (clear_cnt),
        .inc   (in_run),
        .count (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_retire_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (clear_cnt),
        .inc   (in_run && retire),
        .count (retire_cnt)
    );

    sat_counter #(.W(CNT_W)) u_wdog_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (clear_cnt || (in_run && retire)),
        .inc   (in_run && !retire),
        .count (wdog_cnt)
    );

endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller: directed corner runs plus randomized runs against a run-level model.
module tb_run_controller;

    localparam int RST_CYCLES  = 2;
    localparam int MAX_CYCLES  = 100;
    localparam int WDOG_CYCLES = 32;
    localparam int CNT_W       = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             halt;
    logic             retire;
    logic             core_rst_n;
    logic             busy;
    logic             done;
    logic [1:0]       status;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] retire_cnt;

    int tests = 0;
    int fails = 0;

    bit ret_a  [1:256];
    bit halt_a [1:256];
    int exp_k;
    int exp_stat;
    int exp_ret;

    run_controller #(
        .RST_CYCLES  (RST_CYCLES),
        .MAX_CYCLES  (MAX_CYCLES),
        .WDOG_CYCLES (WDOG_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .halt       (halt),
        .retire     (retire),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .status     (status),
        .cycle_cnt  (cycle_cnt),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    // Run-level model: walk the planned RUN cycles and find where and why the run stops.
    task automatic model();
        int  wd;
        bit  stop;
        wd       = 0;
        stop     = 1'b0;
        exp_ret  = 0;
        exp_k    = 0;
        exp_stat = 0;
        for (int k = 1; k <= 256 && !stop; k++) begin
            if (ret_a[k]) begin
                exp_ret++;
                wd = 0;
            end else begin
                wd++;
            end
            if (halt_a[k])              begin exp_stat = 1; stop = 1'b1; end
            else if (k >= MAX_CYCLES)   begin exp_stat = 2; stop = 1'b1; end
            else if (wd >= WDOG_CYCLES) begin exp_stat = 3; stop = 1'b1; end
            if (stop) exp_k = k;
        end
    endtask

    task automatic plan(input int ret_pct, input int halt_at, input int halt_pct);
        for (int k = 1; k <= 256; k++) begin
            ret_a[k]  = ($urandom_range(0, 99) < ret_pct);
            halt_a[k] = (k == halt_at) || ($urandom_range(0, 999) < halt_pct);
        end
    endtask

    task automatic run_once(input string name);
        int low;
        int k;
        int ret_seen;
        bit ended;
        logic [CNT_W-1:0] c_frz, r_frz;
        logic [1:0] s_frz;
        model();
        @(negedge clk);
        start  = 1'b1;
        halt   = 1'($urandom_range(0, 1));
        retire = 1'($urandom_range(0, 1));
        @(negedge clk);
        start = 1'b0;
        tests++;
        if ({busy, done, status, core_rst_n} !== 5'b1_0_00_0) begin
            fails++;
            $display("FAIL %s rst_entry flags: got %b expected %b", name, {busy, done, status, core_rst_n}, 5'b10000);
        end
        tests++;
        if ({cycle_cnt, retire_cnt} !== '0) begin
            fails++;
            $display("FAIL %s rst_entry counters: got %0d/%0d expected 0/0", name, cycle_cnt, retire_cnt);
        end
        low = 1;
        while (!core_rst_n && low < 20) begin
            start  = 1'($urandom_range(0, 1));
            halt   = 1'($urandom_range(0, 1));
            retire = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (!core_rst_n) low++;
        end
        tests++;
        if (low != RST_CYCLES || core_rst_n !== 1'b1) begin
            fails++;
            $display("FAIL %s core_rst_low_cycles: got %0d expected %0d", name, low, RST_CYCLES);
        end
        k        = 1;
        ret_seen = 0;
        ended    = 1'b0;
        while (!ended && k <= 255) begin
            retire = ret_a[k];
            halt   = halt_a[k];
            start  = ($urandom_range(0, 4) == 0);
            if (ret_a[k]) ret_seen++;
            @(negedge clk);
            tests++;
            if (cycle_cnt !== CNT_W'(k) || retire_cnt !== CNT_W'(ret_seen)) begin
                fails++;
                $display("FAIL %s run_counters@%0d: got %0d/%0d expected %0d/%0d", name, k, cycle_cnt, retire_cnt, k, ret_seen);
            end
            tests++;
            if ({done, busy, core_rst_n} !== ((k == exp_k) ? 3'b100 : 3'b011)) begin
                fails++;
                $display("FAIL %s run_flags@%0d: got %b expected %b", name, k, {done, busy, core_rst_n}, (k == exp_k) ? 3'b100 : 3'b011);
            end
            if (done) ended = 1'b1;
            k++;
        end
        start = 1'b0;
        tests++;
        if (!ended) begin
            fails++;
            $display("FAIL %s end_timeout: got no done expected done after %0d cycles", name, exp_k);
        end
        tests++;
        if (status !== 2'(exp_stat) || cycle_cnt !== CNT_W'(exp_k) || retire_cnt !== CNT_W'(exp_ret)) begin
            fails++;
            $display("FAIL %s end_result: got st=%0d cyc=%0d ret=%0d expected st=%0d cyc=%0d ret=%0d",
                     name, status, cycle_cnt, retire_cnt, exp_stat, exp_k, exp_ret);
        end
        c_frz = cycle_cnt;
        r_frz = retire_cnt;
        s_frz = status;
        repeat (3) begin
            halt   = 1'($urandom_range(0, 1));
            retire = 1'($urandom_range(0, 1));
            @(negedge clk);
            tests++;
            if ({cycle_cnt, retire_cnt, status, done, core_rst_n} !== {c_frz, r_frz, s_frz, 1'b1, 1'b0}) begin
                fails++;
                $display("FAIL %s end_frozen: got cyc=%0d ret=%0d st=%0d done=%b expected cyc=%0d ret=%0d st=%0d done=1",
                         name, cycle_cnt, retire_cnt, status, done, c_frz, r_frz, s_frz);
            end
        end
        halt   = 1'b0;
        retire = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        start  = 1'b0;
        halt   = 1'b0;
        retire = 1'b0;
        #1;
        tests++;
        if ({core_rst_n, busy, done, status, cycle_cnt, retire_cnt} !== '0) begin
            fails++;
            $display("FAIL reset_values: got rst_n=%b busy=%b done=%b st=%0d cyc=%0d ret=%0d expected all 0",
                     core_rst_n, busy, done, status, cycle_cnt, retire_cnt);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        halt   = 1'b1;
        retire = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({core_rst_n, busy, done, cycle_cnt, retire_cnt} !== '0) begin
            fails++;
            $display("FAIL idle_after_release: got rst_n=%b busy=%b done=%b cyc=%0d ret=%0d expected all 0",
                     core_rst_n, busy, done, cycle_cnt, retire_cnt);
        end
        halt   = 1'b0;
        retire = 1'b0;
    endtask

    task automatic test_halt();
        plan(100, 10, 0);
        run_once("halt_at_10");
    endtask

    task automatic test_budget();
        plan(100, 0, 0);
        run_once("budget");
    endtask

    task automatic test_watchdog();
        plan(0, 0, 0);
        run_once("watchdog");
    endtask

    task automatic test_halt_budget();
        plan(100, MAX_CYCLES, 0);
        run_once("halt_and_budget");
    endtask

    task automatic test_restart();
        plan(50, 0, 20);
        run_once("restart_from_end");
    endtask

    task automatic test_reset_midrun();
        int guard;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!core_rst_n && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        retire = 1'b1;
        for (int k = 1; k < 50; k++) begin
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start = 1'b0;
        tests++;
        if (cycle_cnt !== CNT_W'(49) || busy !== 1'b1) begin
            fails++;
            $display("FAIL midrun_before_reset: got cyc=%0d busy=%b expected cyc=49 busy=1", cycle_cnt, busy);
        end
        #1 reset = 1'b0;
        #1;
        tests++;
        if ({core_rst_n, busy, done, status, cycle_cnt, retire_cnt} !== '0) begin
            fails++;
            $display("FAIL midrun_reset: got rst_n=%b busy=%b done=%b st=%0d cyc=%0d ret=%0d expected all 0",
                     core_rst_n, busy, done, status, cycle_cnt, retire_cnt);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        tests++;
        if ({core_rst_n, busy, done, cycle_cnt, retire_cnt} !== '0) begin
            fails++;
            $display("FAIL midrun_stays_idle: got rst_n=%b busy=%b done=%b cyc=%0d ret=%0d expected all 0",
                     core_rst_n, busy, done, cycle_cnt, retire_cnt);
        end
        retire = 1'b0;
    endtask

    task automatic test_random();
        int pcts [4] = '{0, 70, 95, 100};
        for (int i = 0; i < 16; i++) begin
            plan(pcts[$urandom_range(0, 3)], 0, $urandom_range(0, 30));
            run_once($sformatf("random_%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_halt();
        test_budget();
        test_watchdog();
        test_halt_budget();
        test_restart();
        test_reset_midrun();
        test_halt();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 2: number of cycles core_rst_n is held low after start.
REQ-002 SHALL have parameter MAX_CYCLES, default 100: RUN-cycle budget.
REQ-003 SHALL have parameter WDOG_CYCLES, default 32: maximum consecutive RUN cycles without a retire.
REQ-004 SHALL have parameter CNT_W, default 32: width of cycle_cnt, retire_cnt and the watchdog counter.
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1: request to begin a run; acted on only in IDLE or END.
REQ-008 SHALL have port halt, input, 1: core halt indication.
REQ-009 SHALL have port retire, input, 1: one instruction retired this cycle.
REQ-010 SHALL have port core_rst_n, output, 1: registered active-low reset to the core under control.
REQ-011 SHALL have port busy, output, 1: high in RST or RUN.
REQ-012 SHALL have port done, output, 1: high in END.
REQ-013 SHALL have port status, output, 2: 00 none, 01 halted, 10 budget expired, 11 watchdog.
REQ-014 SHALL have ports cycle_cnt and retire_cnt, output, CNT_W each: RUN-cycle count and retired-instruction count.

Function
REQ-015 SHALL implement FSM states IDLE, RST, RUN and END.
REQ-016 IDLE: start SHALL move to RST, clear all counters and set status to 00.
REQ-017 RST: SHALL hold core_rst_n low for exactly RST_CYCLES cycles, then enter RUN.
REQ-018 core_rst_n SHALL be high in every RUN cycle and low in all other states.
REQ-019 Latency: start sampled at edge t -> RST at t+1 -> core_rst_n rises at t+1+RST_CYCLES.
REQ-020 RUN: cycle_cnt SHALL increment every RUN cycle, including the terminating cycle.
REQ-021 RUN: retire_cnt SHALL increment in each cycle where retire=1.
REQ-022 Watchdog counter SHALL clear on retire and otherwise increment each RUN cycle.
REQ-023 Termination, evaluated each RUN cycle with priority halt > budget > watchdog:
- halt=1 -> END, status 01.
- else cycle_cnt reaches MAX_CYCLES -> END, status 10.
- else watchdog reaches WDOG_CYCLES -> END, status 11.
REQ-024 END: counters and status SHALL be frozen; start SHALL restart the run as from IDLE (clear counters, enter RST).
REQ-025 start in RST or RUN SHALL be ignored; halt and retire outside RUN SHALL be ignored.
REQ-026 All counters SHALL saturate at all-ones and never wrap.
REQ-027 Outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-028 reset low SHALL asynchronously force:
- state IDLE;
- core_rst_n=0, busy=0, done=0, status=00;
- all counters 0.
REQ-029 reset low in any state (including mid-RUN) SHALL abort the run; no status is retained.
REQ-030 Release of reset SHALL leave the block in IDLE until start.

Structure
REQ-031 A shared package run_ctrl_pkg SHALL hold the FSM state type and the status encodings (STAT_NONE, STAT_HALT, STAT_BUDGET, STAT_WDOG).
REQ-032 A sub-module sat_counter SHALL provide the CNT_W-wide saturating counter with clear and inc inputs; it is instantiated for cycle, retire and watchdog counts.

Verification (default parameters)
REQ-033 start, retire every cycle, halt in RUN cycle 10 -> done=1, status 01, cycle_cnt 10, retire_cnt 10.
REQ-034 retire every cycle, no halt -> END after RUN cycle 100, status 10, cycle_cnt 100, retire_cnt 100.
REQ-035 no retire, no halt -> status 11, cycle_cnt 32, retire_cnt 0.
REQ-036 halt and budget coincide in RUN cycle 100 -> status 01.
REQ-037 start pulses during RUN are ignored; reset low at RUN cycle 50 -> immediately IDLE, core_rst_n 0, counters 0, done 0.
REQ-038 start in END -> counters cleared, status 00, core_rst_n low for exactly 2 cycles, then a new run.
